// File: rtl/bso_pkg.sv
// bso_pkg: shared event indices, count limits and widths for the ball/strike/out sequencer
package bso_pkg;
  localparam int NEV = 5;
  localparam int EV_BALL = 0;
  localparam int EV_FOUL = 1;
  localparam int EV_STRIKE = 2;
  localparam int EV_HIT = 3;
  localparam int EV_OUT = 4;
  localparam int CNT_W = 2;
  localparam int INN_W = 4;
  localparam logic [CNT_W-1:0] MAX_BALL = 2'd3;
  localparam logic [CNT_W-1:0] MAX_STRIKE = 2'd2;
  localparam logic [CNT_W-1:0] MAX_OUT = 2'd2;
endpackage

// File: rtl/bso_evt_arb.sv
// bso_evt_arb: per-event pending bits with fixed-priority one-hot grant (highest index wins)
module bso_evt_arb
  import bso_pkg::*;
(
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iCLR,
  input  logic [NEV-1:0] iREQ,
  input  logic           iBLOCK,
  output logic [NEV-1:0] oGNT,
  output logic           oBUSY
);
  logic [NEV-1:0] pend;
  logic [NEV-1:0] cand;
  // candidates are pending or newly arriving events; OUT sits at the top index so it wins
  always_comb begin
    cand = (iCLR | iBLOCK) ? '0 : pend | iREQ;
    oGNT = '0;
    for (int i = 0; i < NEV; i++)
      if (cand[i]) begin
        oGNT = '0;
        oGNT[i] = 1'b1;
      end
  end
  // granted event retires, the rest stay pending; repeats of a pending event merge
  always_ff @(posedge iCLK)
    if (iRST) pend <= '0;
    else pend <= cand & ~oGNT;
  assign oBUSY = |pend;
endmodule

// File: rtl/bso_count_ctrl.sv
// bso_count_ctrl: scoreboard count state driven by one arbitrated event per clock
module bso_count_ctrl
  import bso_pkg::*;
#(
  parameter int MAX_INNING = 9
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iBALL,
  input  logic             iSTRIKE,
  input  logic             iFOUL,
  input  logic             iHIT,
  input  logic             iOUT,
  input  logic             iCLR,
  output logic [CNT_W-1:0] oBALL,
  output logic [CNT_W-1:0] oSTRIKE,
  output logic [CNT_W-1:0] oOUT,
  output logic [INN_W-1:0] oINNING,
  output logic             oTOP,
  output logic             oWALK,
  output logic             oKO,
  output logic             oSIDE,
  output logic             oGAME_END,
  output logic             oBUSY
);
  logic [NEV-1:0] req, gnt;
  logic [CNT_W-1:0] ball_n, strike_n, out_n;
  logic [INN_W-1:0] inning_n;
  logic top_n, walk_n, ko_n, side_n, end_n, ko, retire;
  assign req = {iOUT, iHIT, iSTRIKE, iFOUL, iBALL};
  assign ko = gnt[EV_STRIKE] & (oSTRIKE == MAX_STRIKE);
  assign retire = gnt[EV_OUT] | ko;
  bso_evt_arb u_arb (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iCLR  (iCLR),
    .iREQ  (req),
    .iBLOCK(oGAME_END),
    .oGNT  (gnt),
    .oBUSY (oBUSY)
  );
  // apply the single granted event; a strikeout reuses the out path in the same cycle
  always_comb begin
    ball_n = oBALL;
    strike_n = oSTRIKE;
    out_n = oOUT;
    inning_n = oINNING;
    top_n = oTOP;
    end_n = oGAME_END;
    walk_n = gnt[EV_BALL] & (oBALL == MAX_BALL);
    ko_n = ko;
    side_n = retire & (oOUT == MAX_OUT);
    if (gnt[EV_BALL]) ball_n = walk_n ? '0 : oBALL + 1'b1;
    if ((gnt[EV_FOUL] | gnt[EV_STRIKE]) && oSTRIKE != MAX_STRIKE) strike_n = oSTRIKE + 1'b1;
    if (walk_n | gnt[EV_HIT] | retire) begin
      ball_n = '0;
      strike_n = '0;
    end
    if (retire) out_n = side_n ? '0 : oOUT + 1'b1;
    if (side_n) begin
      if (oTOP) top_n = 1'b0;
      else if (oINNING == INN_W'(MAX_INNING)) end_n = 1'b1;
      else begin
        top_n = 1'b1;
        inning_n = oINNING + 1'b1;
      end
    end
  end
  // count registers; reset and new-game clear share the same start-of-game values
  always_ff @(posedge iCLK)
    if (iRST | iCLR) begin
      oBALL <= '0;
      oSTRIKE <= '0;
      oOUT <= '0;
      oINNING <= INN_W'(1);
      oTOP <= 1'b1;
      oWALK <= 1'b0;
      oKO <= 1'b0;
      oSIDE <= 1'b0;
      oGAME_END <= 1'b0;
    end else begin
      oBALL <= ball_n;
      oSTRIKE <= strike_n;
      oOUT <= out_n;
      oINNING <= inning_n;
      oTOP <= top_n;
      oWALK <= walk_n;
      oKO <= ko_n;
      oSIDE <= side_n;
      oGAME_END <= end_n;
    end
endmodule

// File: tb/tb_bso_count_ctrl.sv
// tb_bso_count_ctrl: directed vector table, hand sequences and random run against a reference model
module tb_bso_count_ctrl;
  localparam int MAXI = 9;
  localparam logic [4:0] B = 5'b00001, F = 5'b00010, S = 5'b00100, H = 5'b01000, O = 5'b10000;
  localparam logic [14:0] RST_V = {2'd0, 2'd0, 2'd0, 4'd1, 1'b1, 5'b00000};
  localparam int P_BALL = 0, P_FOUL = 1, P_STRIKE = 2, P_HIT = 3, P_OUT = 4;

  logic clk = 0, rst = 1, clr = 0;
  logic ball = 0, strike = 0, foul = 0, hit = 0, out = 0;
  logic [1:0] o_ball, o_strike, o_out;
  logic [3:0] o_inning;
  logic o_top, o_walk, o_ko, o_side, o_end, o_busy;
  int errors = 0, checks = 0;

  int m_ball, m_str, m_out, m_inn;
  bit m_top, m_walk, m_ko, m_side, m_end;
  bit [4:0] m_pend;
  int order[5] = '{P_OUT, P_HIT, P_STRIKE, P_FOUL, P_BALL};

  typedef struct {
    logic [4:0] req;
    logic clr;
    logic [1:0] ball, str, out;
    logic walk, ko, busy;
  } vec_t;
  vec_t tv[$];

  bso_count_ctrl #(.MAX_INNING(MAXI)) dut (
    .iCLK(clk), .iRST(rst), .iBALL(ball), .iSTRIKE(strike), .iFOUL(foul),
    .iHIT(hit), .iOUT(out), .iCLR(clr),
    .oBALL(o_ball), .oSTRIKE(o_strike), .oOUT(o_out), .oINNING(o_inning),
    .oTOP(o_top), .oWALK(o_walk), .oKO(o_ko), .oSIDE(o_side),
    .oGAME_END(o_end), .oBUSY(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] dut_v();
    return {o_ball, o_strike, o_out, o_inning, o_top, o_walk, o_ko, o_side, o_end, o_busy};
  endfunction

  function automatic logic [14:0] model_v();
    return {2'(m_ball), 2'(m_str), 2'(m_out), 4'(m_inn), m_top, m_walk, m_ko, m_side, m_end, |m_pend};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ball = 0; m_str = 0; m_out = 0; m_inn = 1;
    m_top = 1; m_walk = 0; m_ko = 0; m_side = 0; m_end = 0; m_pend = '0;
  endtask

  task automatic model_retire();
    m_ball = 0;
    m_str = 0;
    m_out++;
    if (m_out == 3) begin
      m_out = 0;
      m_side = 1;
      if (m_top) m_top = 0;
      else if (m_inn == MAXI) m_end = 1;
      else begin
        m_top = 1;
        m_inn++;
      end
    end
  endtask

  task automatic model_step(input logic [4:0] r, input logic c, input logic rs);
    bit [4:0] cand;
    int ev;
    m_walk = 0; m_ko = 0; m_side = 0;
    if (rs || c) begin
      model_reset();
      return;
    end
    if (m_end) begin
      m_pend = '0;
      return;
    end
    cand = m_pend | r;
    ev = -1;
    for (int k = 0; k < 5; k++) if (ev < 0 && cand[order[k]]) ev = order[k];
    m_pend = cand;
    if (ev >= 0) m_pend[ev] = 0;
    case (ev)
      P_BALL: if (m_ball == 3) begin m_ball = 0; m_str = 0; m_walk = 1; end else m_ball++;
      P_FOUL: if (m_str < 2) m_str++;
      P_STRIKE: if (m_str < 2) m_str++; else begin m_ko = 1; model_retire(); end
      P_HIT: begin m_ball = 0; m_str = 0; end
      P_OUT: model_retire();
      default: ;
    endcase
  endtask

  task automatic step(input logic [4:0] r, input logic c, input logic rs);
    {out, hit, strike, foul, ball} = r;
    clr = c;
    rst = rs;
    model_step(r, c, rs);
    @(posedge clk);
    #1;
    {out, hit, strike, foul, ball} = '0;
    clr = 0;
    rst = 0;
    check("model", dut_v(), model_v());
  endtask

  function automatic vec_t mk(input logic [4:0] r, input logic c, input int b, input int s,
                              input int o, input logic w, input logic k, input logic bz);
    vec_t v;
    v.req = r; v.clr = c; v.ball = 2'(b); v.str = 2'(s); v.out = 2'(o);
    v.walk = w; v.ko = k; v.busy = bz;
    return v;
  endfunction

  initial begin
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("reset", dut_v(), RST_V);

    tv.push_back(mk(B, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(B, 0, 2, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0));
    tv.push_back(mk(B, 0, 3, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0));
    tv.push_back(mk(B, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(S, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(F, 0, 0, 2, 0, 0, 0, 0));
    tv.push_back(mk(F, 0, 0, 2, 0, 0, 0, 0));
    tv.push_back(mk(F, 0, 0, 2, 0, 0, 0, 0));
    tv.push_back(mk(S, 0, 0, 0, 1, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(B | S | O, 0, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(H, 0, 0, 0, 1, 0, 0, 0));
    foreach (tv[i]) begin
      step(tv[i].req, tv[i].clr, 0);
      check($sformatf("vec%0d", i), {o_ball, o_strike, o_out, o_walk, o_ko, o_busy},
            {tv[i].ball, tv[i].str, tv[i].out, tv[i].walk, tv[i].ko, tv[i].busy});
    end

    step(0, 1, 0);
    step(O, 0, 0);
    step(O, 0, 0);
    check("two_outs", {o_out, o_side, o_top}, {2'd2, 1'b0, 1'b1});
    step(O, 0, 0);
    check("side_top1", {o_side, o_top, o_inning, o_out}, {1'b1, 1'b0, 4'd1, 2'd0});
    repeat (3) step(O, 0, 0);
    check("side_bot1", {o_side, o_top, o_inning}, {1'b1, 1'b1, 4'd2});

    repeat (47) step(O, 0, 0);
    check("bot_last", {o_inning, o_top, o_out, o_end}, {4'd9, 1'b0, 2'd2, 1'b0});
    step(O, 0, 0);
    check("game_end", {o_end, o_side, o_inning, o_top, o_out}, {1'b1, 1'b1, 4'd9, 1'b0, 2'd0});
    step(B | O, 0, 0);
    step(S, 0, 0);
    check("ignored", {o_ball, o_strike, o_out, o_end, o_busy, o_inning, o_top},
          {2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd9, 1'b0});
    step(0, 1, 0);
    check("clr_end", dut_v(), RST_V);

    step(B, 0, 0);
    step(S, 0, 0);
    step(O | B, 0, 0);
    check("pend_ob", {o_out, o_ball, o_busy}, {2'd1, 2'd0, 1'b1});
    step(O | F, 1, 0);
    check("clr_pend", dut_v(), RST_V);
    step(0, 0, 0);
    check("clr_drop", dut_v(), RST_V);
    step(B, 0, 0);
    step(O | B | H, 0, 0);
    step(B, 1, 1);
    check("rst_clr", dut_v(), RST_V);
    step(0, 0, 0);
    check("rst_busy", {o_busy, o_ball}, {1'b0, 2'd0});

    for (int n = 0; n < 4000; n++) begin
      logic [4:0] r;
      for (int b = 0; b < 5; b++) r[b] = ($urandom_range(0, 3) == 0);
      step(r, $urandom_range(0, 299) == 0, $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
